// File: rtl/qsfp_link_pkg.sv
// Shared state encoding and counter sizing helpers for the QSFP-to-HDMI link sequencer.
package qsfp_link_pkg;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_HOLD_RESET = 4'd1;
  localparam logic [3:0] ST_SETTLE     = 4'd2;
  localparam logic [3:0] ST_CONFIG     = 4'd3;
  localparam logic [3:0] ST_BACKOFF    = 4'd4;
  localparam logic [3:0] ST_WAIT_TX    = 4'd5;
  localparam logic [3:0] ST_RUN        = 4'd6;
  localparam logic [3:0] ST_FAULT      = 4'd7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a down-counter that is loaded with (max_val - 1).
  function automatic int cnt_width(input int max_val);
    return ($clog2(max_val) < 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/hpd_debouncer.sv
// Two-flop synchronizer followed by an asymmetric hold-off filter:
// long qualification on rise, shorter on fall.
module hpd_debouncer
  import qsfp_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int LOSS_CYCLES     = 200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = cnt_width(max_int(DEBOUNCE_CYCLES, LOSS_CYCLES));
  localparam logic [CW-1:0] RISE_LOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FALL_LOAD = CW'(LOSS_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= RISE_LOAD;
    end else begin
      meta <= raw;
      sync <= meta;
      // Any sample that agrees with the filtered level restarts the window.
      if (sync == stable) begin
        cnt <= stable ? FALL_LOAD : RISE_LOAD;
      end else if (cnt == '0) begin
        stable <= sync;
        cnt    <= sync ? FALL_LOAD : RISE_LOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/qsfp_hdmi_link_sequencer.sv
// Per-port QSFP-to-HDMI bring-up: hot-plug qualify, module reset, settle,
// config handshake with retry/backoff, TX-ready gating, LEDs and teardown.
module qsfp_hdmi_link_sequencer
  import qsfp_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES       = 2_000_000,
  parameter int LOSS_CYCLES           = 200_000,
  parameter int RESET_HOLD_CYCLES     = 400_000,
  parameter int SETTLE_CYCLES         = 40_000_000,
  parameter int CONFIG_TIMEOUT_CYCLES = 20_000_000,
  parameter int BACKOFF_CYCLES        = 20_000_000,
  parameter int RETRY_LIMIT           = 3,
  parameter int BLINK_HALF_CYCLES     = 50_000_000
) (
  input  logic       system_clock,
  input  logic       system_reset,
  input  logic       hpd_raw,
  input  logic       tx_ready,
  input  logic       config_done,
  input  logic       config_error,
  output logic       config_start,
  output logic       module_resetl,
  output logic       video_enable,
  output logic       led_y,
  output logic       led_g,
  output logic       fault,
  output logic [3:0] state
);

  localparam int TW = cnt_width(max_int(max_int(RESET_HOLD_CYCLES, SETTLE_CYCLES),
                                        max_int(CONFIG_TIMEOUT_CYCLES, BACKOFF_CYCLES)));
  localparam int RW = cnt_width(RETRY_LIMIT + 1);
  localparam int BW = cnt_width(BLINK_HALF_CYCLES);

  logic          hpd_stable;
  logic          tx_meta;
  logic          tx_sync;
  logic [3:0]    nstate;
  logic [TW-1:0] timer;
  logic [TW-1:0] reload_val;
  logic [RW-1:0] retry_cnt;
  logic          cfg_fail;
  logic [BW-1:0] presc;
  logic          blink;

  hpd_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LOSS_CYCLES     (LOSS_CYCLES)
  ) u_hpd (
    .clk    (system_clock),
    .rst    (system_reset),
    .raw    (hpd_raw),
    .stable (hpd_stable)
  );

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      tx_meta <= 1'b0;
      tx_sync <= 1'b0;
    end else begin
      tx_meta <= tx_ready;
      tx_sync <= tx_meta;
    end
  end

  // Watchdog expiry and NACK are treated the same way.
  assign cfg_fail = (state == ST_CONFIG) && (config_error || (timer == '0));

  always_comb begin
    nstate = state;
    if ((state != ST_IDLE) && !hpd_stable) begin
      nstate = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (hpd_stable)    nstate = ST_HOLD_RESET;
        ST_HOLD_RESET: if (timer == '0)   nstate = ST_SETTLE;
        ST_SETTLE:     if (timer == '0)   nstate = ST_CONFIG;
        ST_CONFIG: begin
          if (cfg_fail)
            nstate = (retry_cnt == RW'(RETRY_LIMIT - 1)) ? ST_FAULT : ST_BACKOFF;
          else if (config_done)
            nstate = ST_WAIT_TX;
        end
        ST_BACKOFF:    if (timer == '0)   nstate = ST_CONFIG;
        ST_WAIT_TX:    if (tx_sync)       nstate = ST_RUN;
        ST_RUN:        if (!tx_sync)      nstate = ST_WAIT_TX;
        ST_FAULT:                         nstate = ST_FAULT;
        default:                          nstate = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    reload_val = '0;
    case (nstate)
      ST_HOLD_RESET: reload_val = TW'(RESET_HOLD_CYCLES - 1);
      ST_SETTLE:     reload_val = TW'(SETTLE_CYCLES - 1);
      ST_CONFIG:     reload_val = TW'(CONFIG_TIMEOUT_CYCLES - 1);
      ST_BACKOFF:    reload_val = TW'(BACKOFF_CYCLES - 1);
      default:       reload_val = '0;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      presc <= BW'(BLINK_HALF_CYCLES - 1);
      blink <= 1'b0;
    end else if (presc == '0) begin
      presc <= BW'(BLINK_HALF_CYCLES - 1);
      blink <= ~blink;
    end else begin
      presc <= presc - BW'(1);
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      retry_cnt     <= '0;
      config_start  <= 1'b0;
      module_resetl <= 1'b0;
      video_enable  <= 1'b0;
      led_y         <= 1'b0;
      led_g         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state <= nstate;
      if (nstate != state)
        timer <= reload_val;
      else if (timer != '0)
        timer <= timer - TW'(1);

      if (nstate == ST_IDLE)
        retry_cnt <= '0;
      else if (cfg_fail)
        retry_cnt <= retry_cnt + RW'(1);

      config_start  <= (nstate == ST_CONFIG) && (state != ST_CONFIG);
      module_resetl <= !((nstate == ST_IDLE) || (nstate == ST_HOLD_RESET));
      video_enable  <= (nstate == ST_RUN);
      led_g         <= (nstate == ST_RUN);
      fault         <= (nstate == ST_FAULT);
      led_y         <= (nstate == ST_FAULT) ? blink : (hpd_stable && (nstate != ST_RUN));
    end
  end

endmodule

// File: tb/tb_qsfp_hdmi_link_sequencer.sv
// Directed bench for the link sequencer using short timing parameters.
module tb_qsfp_hdmi_link_sequencer;

  localparam logic [3:0] S_IDLE = 4'd0, S_HOLD = 4'd1, S_SETTLE = 4'd2, S_CONFIG = 4'd3,
                         S_BACKOFF = 4'd4, S_WAIT_TX = 4'd5, S_RUN = 4'd6, S_FAULT = 4'd7;

  logic       system_clock = 1'b0;
  logic       system_reset = 1'b1;
  logic       hpd_raw = 1'b0, tx_ready = 1'b0, config_done = 1'b0, config_error = 1'b0;
  logic       config_start, module_resetl, video_enable, led_y, led_g, fault;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  int start_count = 0;

  qsfp_hdmi_link_sequencer #(
    .DEBOUNCE_CYCLES(8), .LOSS_CYCLES(4), .RESET_HOLD_CYCLES(4), .SETTLE_CYCLES(16),
    .CONFIG_TIMEOUT_CYCLES(32), .BACKOFF_CYCLES(10), .RETRY_LIMIT(2), .BLINK_HALF_CYCLES(4)
  ) dut (
    .system_clock(system_clock), .system_reset(system_reset), .hpd_raw(hpd_raw),
    .tx_ready(tx_ready), .config_done(config_done), .config_error(config_error),
    .config_start(config_start), .module_resetl(module_resetl), .video_enable(video_enable),
    .led_y(led_y), .led_g(led_g), .fault(fault), .state(state)
  );

  always #5 system_clock = ~system_clock;

  always @(negedge system_clock) if (config_start) start_count++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic do_reset();
    system_reset = 1'b1;
    hpd_raw = 1'b0; tx_ready = 1'b0; config_done = 1'b0; config_error = 1'b0;
    tick(); tick();
    system_reset = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < limit) begin
      tick();
      i++;
      if (state === s) n = i;
    end
  endtask

  task automatic wait_start(input int limit, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < limit) begin
      tick();
      i++;
      if (config_start === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    system_reset = 1'b1; hpd_raw = 1'b1; tx_ready = 1'b1;
    tick(); tick();
    got = {state, module_resetl, video_enable, config_start, led_y, led_g, fault};
    tests++;
    if (got !== 10'b0) begin
      fails++;
      $display("FAIL reset_values: got %b expected %b", got, 10'b0);
    end
    do_reset();
  endtask

  task automatic test_clean_plug();
    int n;
    int s0;
    do_reset();
    s0 = start_count;
    hpd_raw = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 11) begin
        tests++;
        if (state !== S_HOLD) begin fails++; $display("FAIL plug_hold_entry: got %0d expected %0d", state, S_HOLD); end
      end
      if (i == 14) begin
        tests++;
        if (module_resetl !== 1'b0) begin fails++; $display("FAIL plug_resetl_low: got %b expected 0", module_resetl); end
      end
    end
    tests++;
    if (module_resetl !== 1'b1 || state !== S_SETTLE || led_y !== 1'b1) begin
      fails++;
      $display("FAIL plug_resetl_release: resetl=%b state=%0d led_y=%b expected 1 2 1", module_resetl, state, led_y);
    end
    wait_start(40, n);
    tests++;
    if (n !== 16) begin fails++; $display("FAIL plug_settle_len: got %0d expected 16", n); end
    repeat (4) tick();
    config_done = 1'b1; tick(); config_done = 1'b0;
    tests++;
    if (state !== S_WAIT_TX) begin fails++; $display("FAIL plug_wait_tx: got %0d expected %0d", state, S_WAIT_TX); end
    tx_ready = 1'b1;
    tick(); tick();
    tests++;
    if (video_enable !== 1'b0) begin fails++; $display("FAIL plug_video_early: got %b expected 0", video_enable); end
    tick();
    tests++;
    if (state !== S_RUN || video_enable !== 1'b1 || led_g !== 1'b1 || led_y !== 1'b0) begin
      fails++;
      $display("FAIL plug_run: state=%0d video=%b led_g=%b led_y=%b expected 6 1 1 0", state, video_enable, led_g, led_y);
    end
    tests++;
    if (start_count - s0 !== 1) begin fails++; $display("FAIL plug_start_count: got %0d expected 1", start_count - s0); end
  endtask

  task automatic test_tx_loss();
    int s0;
    s0 = start_count;
    tx_ready = 1'b0;
    tick(); tick();
    tests++;
    if (state !== S_RUN) begin fails++; $display("FAIL txloss_still_run: got %0d expected %0d", state, S_RUN); end
    tick();
    tests++;
    if (state !== S_WAIT_TX || video_enable !== 1'b0) begin
      fails++;
      $display("FAIL txloss_drop: state=%0d video=%b expected 5 0", state, video_enable);
    end
    tx_ready = 1'b1;
    repeat (3) tick();
    tests++;
    if (state !== S_RUN || video_enable !== 1'b1 || start_count !== s0) begin
      fails++;
      $display("FAIL txloss_recover: state=%0d video=%b starts=%0d expected 6 1 %0d", state, video_enable, start_count, s0);
    end
  endtask

  task automatic test_glitchy_plug();
    int n;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      hpd_raw = ((i % 6) < 3);
      tick();
      if (state !== S_IDLE || module_resetl !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL glitch_idle: got %0d bad cycles expected 0", bad); end
    hpd_raw = 1'b1;
    wait_state(S_HOLD, 30, n);
    tests++;
    if (n !== 11) begin fails++; $display("FAIL glitch_accept: got %0d cycles expected 11", n); end
  endtask

  task automatic test_retry_fault();
    int n;
    int s0;
    int hi;
    int lo;
    do_reset();
    hpd_raw = 1'b1;
    wait_start(60, n);
    tests++;
    if (n !== 31) begin fails++; $display("FAIL retry_first_start: got %0d expected 31", n); end
    tick(); tick();
    config_error = 1'b1; tick(); config_error = 1'b0;
    tests++;
    if (state !== S_BACKOFF) begin fails++; $display("FAIL retry_backoff: got %0d expected %0d", state, S_BACKOFF); end
    wait_start(20, n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL retry_backoff_len: got %0d expected 10", n); end
    wait_state(S_FAULT, 50, n);
    tests++;
    if (n !== 32) begin fails++; $display("FAIL retry_watchdog: got %0d expected 32", n); end
    tests++;
    if (fault !== 1'b1 || led_g !== 1'b0 || module_resetl !== 1'b1) begin
      fails++;
      $display("FAIL retry_fault_outputs: fault=%b led_g=%b resetl=%b expected 1 0 1", fault, led_g, module_resetl);
    end
    s0 = start_count; hi = 0; lo = 0;
    config_done = 1'b1; tick(); config_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (led_y === 1'b1) hi++;
      if (led_y === 1'b0) lo++;
    end
    tests++;
    if (hi == 0 || lo == 0) begin fails++; $display("FAIL fault_blink: high=%0d low=%0d expected both nonzero", hi, lo); end
    tests++;
    if (state !== S_FAULT || start_count !== s0) begin
      fails++;
      $display("FAIL fault_sticky: state=%0d starts=%0d expected 7 %0d", state, start_count, s0);
    end
  endtask

  task automatic test_unplug_priority();
    int n;
    do_reset();
    hpd_raw = 1'b1;
    wait_start(60, n);
    tick();
    config_error = 1'b1; tick(); config_error = 1'b0;
    wait_start(20, n);
    hpd_raw = 1'b0;
    repeat (6) tick();
    tests++;
    if (state !== S_CONFIG) begin fails++; $display("FAIL unplug_pre: got %0d expected %0d", state, S_CONFIG); end
    config_done = 1'b1; tick(); config_done = 1'b0;
    tests++;
    if (state !== S_IDLE || video_enable !== 1'b0 || module_resetl !== 1'b0 || fault !== 1'b0 || led_y !== 1'b0) begin
      fails++;
      $display("FAIL unplug_priority: state=%0d video=%b resetl=%b fault=%b led_y=%b expected 0 0 0 0 0",
               state, video_enable, module_resetl, fault, led_y);
    end
    hpd_raw = 1'b1;
    wait_start(60, n);
    tests++;
    if (n !== 31) begin fails++; $display("FAIL unplug_replug_start: got %0d expected 31", n); end
    config_error = 1'b1; tick(); config_error = 1'b0;
    tests++;
    if (state !== S_BACKOFF) begin fails++; $display("FAIL unplug_retry_cleared: got %0d expected %0d", state, S_BACKOFF); end
  endtask

  task automatic test_reset_mid_config();
    int n;
    logic [9:0] got;
    do_reset();
    hpd_raw = 1'b1;
    wait_start(60, n);
    tick(); tick();
    system_reset = 1'b1; tick(); system_reset = 1'b0;
    got = {state, module_resetl, video_enable, config_start, led_y, led_g, fault};
    tests++;
    if (got !== 10'b0) begin fails++; $display("FAIL midreset_values: got %b expected %b", got, 10'b0); end
    wait_state(S_HOLD, 30, n);
    tests++;
    if (n !== 11) begin fails++; $display("FAIL midreset_restart: got %0d expected 11", n); end
    wait_start(40, n);
    tests++;
    if (n !== 20) begin fails++; $display("FAIL midreset_restart_start: got %0d expected 20", n); end
  endtask

  initial begin
    test_reset();
    test_clean_plug();
    test_tx_loss();
    test_glitchy_plug();
    test_retry_fault();
    test_unplug_priority();
    test_reset_mid_config();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
